// File: rtl/hub75_bcm_scheduler.sv
// HUB75 panel sequencer with binary-code-modulated bitplanes.
// Shifting of the next plane overlaps the lit window of the plane just latched.
module hub75_bcm_scheduler #(
  parameter  int unsigned COLS     = 64,
  parameter  int unsigned ROW_BITS = 4,
  parameter  int unsigned PLANES   = 4,
  parameter  int unsigned BASE_ON  = 8,
  localparam int unsigned CW       = $clog2(COLS),
  localparam int unsigned PW       = $clog2(PLANES),
  localparam int unsigned AW       = PW + ROW_BITS + CW
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  output logic [AW-1:0]       o_fb_addr,
  input  logic [5:0]          i_fb_data,
  output logic [1:0]          o_data_r,
  output logic [1:0]          o_data_g,
  output logic [1:0]          o_data_b,
  output logic                o_sclk,
  output logic                o_latch,
  output logic                o_blank,
  output logic [ROW_BITS-1:0] o_row,
  output logic                o_frame_done
);

  localparam int unsigned TW = $clog2((BASE_ON << (PLANES - 1)) + 1);
  localparam logic [CW+1:0] STEP_LAST = (CW+2)'(2 * COLS);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_ON,
    BLANK,
    LATCH,
    UNBLANK,
    DRAIN
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [CW+1:0]       step;
  logic [PW-1:0]       plane;
  logic [ROW_BITS-1:0] row;
  logic [TW-1:0]       timer;
  logic                timer_low;

  // step = {col, ph}; step == 2*COLS is the trailing sclk-high clock
  assign o_fb_addr    = {plane, row, step[CW:1]};
  assign o_latch      = (state == LATCH);
  assign o_blank      = (timer == '0);
  assign o_frame_done = (state == UNBLANK) && (plane == PW'(PLANES - 1)) && (row == '1);
  assign timer_low    = (timer <= TW'(1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (i_enable) state_nx = SHIFT;
      SHIFT:   if (step == STEP_LAST) state_nx = timer_low ? BLANK : WAIT_ON;
      WAIT_ON: if (timer_low) state_nx = BLANK;
      BLANK:   state_nx = LATCH;
      LATCH:   state_nx = UNBLANK;
      UNBLANK: state_nx = i_enable ? SHIFT : DRAIN;
      DRAIN:   if (timer == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      step     <= '0;
      plane    <= '0;
      row      <= '0;
      timer    <= '0;
      o_row    <= '0;
      o_sclk   <= 1'b0;
      o_data_r <= '0;
      o_data_g <= '0;
      o_data_b <= '0;
    end else begin
      state <= state_nx;
      // sclk rises on the clock after every ph1, including the trailing one
      o_sclk <= (state == SHIFT) && step[0];

      if (state == SHIFT) step <= step + (CW+2)'(1);
      else                step <= '0;

      if (state == SHIFT && step[0]) begin
        o_data_r <= {i_fb_data[5], i_fb_data[2]};
        o_data_g <= {i_fb_data[4], i_fb_data[1]};
        o_data_b <= {i_fb_data[3], i_fb_data[0]};
      end

      if (state == UNBLANK)  timer <= TW'(BASE_ON << plane);
      else if (timer != '0) timer <= timer - TW'(1);

      if (state == BLANK) o_row <= row;

      if (state == UNBLANK) begin
        plane <= plane + PW'(1);
        if (plane == PW'(PLANES - 1)) row <= row + ROW_BITS'(1);
      end else if (state == DRAIN && timer == '0) begin
        plane <= '0;
        row   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Bench for hub75_bcm_scheduler: small-geometry instance for sequencing/drain/reset,
// default-geometry instance for shift-bound plane timing.
module tb_hub75_bcm_scheduler;

  localparam int A_COLS  = 4;
  localparam int A_RB    = 1;
  localparam int A_PL    = 2;
  localparam int A_BASE  = 16;
  localparam int A_ROWS  = 1 << A_RB;
  localparam int A_SHIFT = 2 * A_COLS + 1;
  localparam int B_COLS  = 64;
  localparam int B_BASE  = 8;
  localparam int B_PL    = 4;
  localparam int B_SHIFT = 2 * B_COLS + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- instance A (COLS=4, ROW_BITS=1, PLANES=2, BASE_ON=16)
  logic       rst_a = 1'b1;
  logic       en_a  = 1'b0;
  logic [3:0] addr_a;
  logic [5:0] fbd_a;
  logic [1:0] r_a, g_a, b_a;
  logic       sclk_a, latch_a, blank_a, fdone_a;
  logic [0:0] row_a;
  logic [5:0] mem_a [A_PL*A_ROWS*A_COLS];

  always @(posedge clk) fbd_a <= mem_a[addr_a];

  hub75_bcm_scheduler #(.COLS(A_COLS), .ROW_BITS(A_RB), .PLANES(A_PL), .BASE_ON(A_BASE)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_enable(en_a), .o_fb_addr(addr_a), .i_fb_data(fbd_a),
    .o_data_r(r_a), .o_data_g(g_a), .o_data_b(b_a), .o_sclk(sclk_a), .o_latch(latch_a),
    .o_blank(blank_a), .o_row(row_a), .o_frame_done(fdone_a)
  );

  // ---------------- instance B (defaults: COLS=64, ROW_BITS=4, PLANES=4, BASE_ON=8)
  logic        rst_b = 1'b1;
  logic        en_b  = 1'b0;
  logic [11:0] addr_b;
  logic [5:0]  fbd_b;
  logic [1:0]  r_b, g_b, b_b;
  logic        sclk_b, latch_b, blank_b, fdone_b;
  logic [3:0]  row_b;

  always @(posedge clk) fbd_b <= addr_b[5:0];

  hub75_bcm_scheduler #(.COLS(B_COLS), .ROW_BITS(4), .PLANES(B_PL), .BASE_ON(B_BASE)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_enable(en_b), .o_fb_addr(addr_b), .i_fb_data(fbd_b),
    .o_data_r(r_b), .o_data_g(g_b), .o_data_b(b_b), .o_sclk(sclk_b), .o_latch(latch_b),
    .o_blank(blank_b), .o_row(row_b), .o_frame_done(fdone_b)
  );

  // ---------------- monitor A: event logs sampled on the falling edge
  logic       mon_clr = 1'b0;
  int         cyc = 0;
  int         rise_w[$], rise_g[$], latch_row[$], latch_t[$], lit_q[$], fd_q[$];
  int         lit_cnt = 0, latch_bad = 0, row_bad = 0;
  logic       sclk_p = 1'b0, latch_p = 1'b0;
  logic [0:0] row_p = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      rise_w.delete(); rise_g.delete(); latch_row.delete();
      latch_t.delete(); lit_q.delete(); fd_q.delete();
      lit_cnt <= 0; latch_bad <= 0; row_bad <= 0;
    end else begin
      if (sclk_a && !sclk_p) begin
        rise_w.push_back(int'({r_a[1], g_a[1], b_a[1], r_a[0], g_a[0], b_a[0]}));
        rise_g.push_back(int'(addr_a[3:2]));
      end
      if (latch_a) begin
        latch_row.push_back(int'(row_a));
        latch_t.push_back(cyc);
        if (!blank_a || latch_p) latch_bad <= latch_bad + 1;
      end
      if (!blank_a) lit_cnt <= lit_cnt + 1;
      else if (lit_cnt > 0) begin
        lit_q.push_back(lit_cnt);
        lit_cnt <= 0;
      end
      if (row_a != row_p && !blank_a) row_bad <= row_bad + 1;
      if (fdone_a) fd_q.push_back(latch_row.size());
    end
    sclk_p  <= sclk_a;
    latch_p <= latch_a;
    row_p   <= row_a;
  end

  // ---------------- monitor B
  int   rises_b = 0, bad_b = 0, litb_cnt = 0;
  int   latchb_t[$], litb_q[$];
  logic sclkb_p = 1'b0;

  always @(negedge clk) begin
    if (sclk_b && !sclkb_p) begin
      if (rises_b < B_COLS && int'({r_b[1], g_b[1], b_b[1], r_b[0], g_b[0], b_b[0]}) != rises_b)
        bad_b <= bad_b + 1;
      rises_b <= rises_b + 1;
    end
    if (latch_b) latchb_t.push_back(cyc);
    if (!blank_b) litb_cnt <= litb_cnt + 1;
    else if (litb_cnt > 0) begin
      litb_q.push_back(litb_cnt);
      litb_cnt <= 0;
    end
    sclkb_p <= sclk_b;
  end

  // ---------------- reference model for instance A
  function automatic int lit_of(input int k);
    return A_BASE << (k % A_PL);
  endfunction

  function automatic int gap_after(input int k);
    int l;
    l = lit_of(k);
    return ((l > A_SHIFT) ? l : A_SHIFT) + 3;
  endfunction

  function automatic int grp_of(input int k);
    return (k % A_PL) * A_ROWS + (k / A_PL) % A_ROWS;
  endfunction

  function automatic int fdone_of(input int k);
    return ((k % A_PL) == A_PL - 1 && ((k / A_PL) % A_ROWS) == A_ROWS - 1) ? 1 : 0;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int qhas(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1;
    return 0;
  endfunction

  // ---------------- helpers
  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  task automatic wait_latches(input int n, input int budget, input string nm);
    int c = 0;
    while (latch_row.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    check(nm, int'(latch_row.size() >= n), 1);
  endtask

  // which: 0 = sclk high, 1 = lit, 2 = latch high
  task automatic wait_sig(input int which, input int budget, input string nm);
    int c = 0;
    bit hit = 1'b0;
    while (!hit && c < budget) begin
      tick(1);
      c++;
      hit = (which == 0) ? sclk_a : (which == 1) ? !blank_a : latch_a;
    end
    check(nm, int'(hit), 1);
  endtask

  task automatic data_check(input string nm);
    int bad = 0;
    for (int i = 0; i < rise_w.size(); i++)
      if (rise_w[i] != int'(mem_a[4'(grp_of(i / A_COLS) * A_COLS + i % A_COLS)])) bad++;
    check(nm, bad, 0);
  endtask

  typedef struct {
    int plane;
    int row;
    int lit;
    int gap;
    int fd;
  } ev_t;

  ev_t tbl[8];

  initial begin
    int m, mdrop, k, lt, acc, bad, fdn, nexp;

    tbl[0] = '{0, 0, 16,  0, 0};
    tbl[1] = '{1, 0, 32, 19, 0};
    tbl[2] = '{0, 1, 16, 35, 0};
    tbl[3] = '{1, 1, 32, 19, 1};
    tbl[4] = '{0, 0, 16, 35, 0};
    tbl[5] = '{1, 0, 32, 19, 0};
    tbl[6] = '{0, 1, 16, 35, 0};
    tbl[7] = '{1, 1, 32, 19, 1};

    for (int a = 0; a < A_PL * A_ROWS * A_COLS; a++) mem_a[a] = 6'(a);
    tick(1);
    check("reset_blank", int'(blank_a), 1);
    check("reset_sclk", int'(sclk_a), 0);
    check("reset_latch", int'(latch_a), 0);
    check("reset_addr", int'(addr_a), 0);
    tick(2);
    rst_a = 1'b0;
    rst_b = 1'b0;
    clear_mon();

    // two full frames, then drop enable in the UNBLANK of the 8th latch
    m = cyc;
    en_a = 1'b1;
    wait_latches(8, 600, "p1_latch_timeout");
    en_a = 1'b0;
    check("p1_first_shift", qget(latch_t, 0) - m, A_SHIFT + 2);
    tick(80);
    for (int e = 0; e < 8; e++) begin
      check($sformatf("p1_grp%0d", e), qget(rise_g, e * A_COLS), tbl[e].plane * A_ROWS + tbl[e].row);
      check($sformatf("p1_row%0d", e), qget(latch_row, e), tbl[e].row);
      check($sformatf("p1_lit%0d", e), qget(lit_q, e), tbl[e].lit);
      if (e > 0) check($sformatf("p1_gap%0d", e), qget(latch_t, e) - qget(latch_t, e - 1), tbl[e].gap);
      check($sformatf("p1_fdone%0d", e), qhas(fd_q, e + 1), tbl[e].fd);
    end
    data_check("p1_data");
    check("p1_rises", rise_w.size(), 8 * A_COLS);
    check("p1_latches_after_drain", latch_row.size(), 8);
    check("p1_windows_after_drain", lit_q.size(), 8);
    check("p1_fdone_count", fd_q.size(), 2);
    check("p1_blank_idle", int'(blank_a), 1);
    check("p1_latch_in_blank", latch_bad, 0);
    check("p1_row_in_blank", row_bad, 0);

    // asynchronous reset while shifting, while lit and while latching
    en_a = 1'b1;
    wait_sig(0, 100, "t1_reach_sclk");
    rst_a = 1'b1;
    #1;
    check("t1_shift_blank", int'(blank_a), 1);
    check("t1_shift_sclk", int'(sclk_a), 0);
    check("t1_shift_latch", int'(latch_a), 0);
    check("t1_shift_addr", int'(addr_a), 0);
    tick(2);
    rst_a = 1'b0;
    tick(1);
    check("t1_restart_addr", int'(addr_a), 0);
    wait_sig(1, 100, "t1_reach_lit");
    rst_a = 1'b1;
    #1;
    check("t1_lit_blank", int'(blank_a), 1);
    tick(2);
    rst_a = 1'b0;
    wait_sig(2, 100, "t1_reach_latch");
    rst_a = 1'b1;
    #1;
    check("t1_latch_latch", int'(latch_a), 0);
    check("t1_latch_blank", int'(blank_a), 1);
    en_a = 1'b0;
    tick(2);
    rst_a = 1'b0;
    tick(2);

    // random framebuffer contents and random drain point
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 1) begin
        rst_a = 1'b1;
        tick(2);
        rst_a = 1'b0;
        tick(1);
      end
      for (int a = 0; a < A_PL * A_ROWS * A_COLS; a++) mem_a[a] = 6'($urandom_range(0, 63));
      clear_mon();
      m = cyc;
      en_a = 1'b1;
      wait_latches(1, 100, $sformatf("r%0d_first_latch", t));
      tick($urandom_range(0, 150));
      mdrop = cyc;
      en_a = 1'b0;
      tick(200);

      lt = qget(latch_t, 0);
      k = 0;
      while (lt < mdrop - 1 && k < 1000) begin
        lt += gap_after(k);
        k++;
      end
      nexp = k + 1;
      fdn = 0;
      for (int j = 0; j <= k; j++) fdn += fdone_of(j);

      bad = 0;
      acc = qget(latch_t, 0);
      for (int j = 1; j < latch_t.size(); j++) begin
        acc += gap_after(j - 1);
        if (latch_t[j] != acc) bad++;
      end
      check($sformatf("r%0d_latch_timing", t), bad, 0);
      bad = 0;
      for (int j = 0; j < latch_row.size(); j++)
        if (latch_row[j] != (j / A_PL) % A_ROWS) bad++;
      for (int j = 0; j < rise_g.size(); j++)
        if (rise_g[j] != grp_of(j / A_COLS)) bad++;
      check($sformatf("r%0d_order", t), bad, 0);
      check($sformatf("r%0d_first_shift", t), qget(latch_t, 0) - m, A_SHIFT + 2);
      check($sformatf("r%0d_latches", t), latch_row.size(), nexp);
      check($sformatf("r%0d_rises", t), rise_w.size(), nexp * A_COLS);
      check($sformatf("r%0d_windows", t), lit_q.size(), nexp);
      check($sformatf("r%0d_last_lit", t), qget(lit_q, nexp - 1), lit_of(k));
      check($sformatf("r%0d_fdone", t), fd_q.size(), fdn);
      check($sformatf("r%0d_blank_idle", t), int'(blank_a), 1);
      check($sformatf("r%0d_latch_in_blank", t), latch_bad, 0);
      check($sformatf("r%0d_row_in_blank", t), row_bad, 0);
      data_check($sformatf("r%0d_data", t));
    end

    // full-size geometry: shift (129 clks) longer than every plane window
    begin
      int c = 0;
      m = cyc;
      en_b = 1'b1;
      while (latchb_t.size() < 5 && c < 1500) begin
        tick(1);
        c++;
      end
      check("b_latch_timeout", int'(latchb_t.size() >= 5), 1);
      check("b_first_shift", (latchb_t.size() > 0) ? latchb_t[0] - m : -1, B_SHIFT + 2);
      check("b_rises", rises_b, 5 * B_COLS);
      check("b_data", bad_b, 0);
      for (int j = 0; j < B_PL; j++) begin
        check($sformatf("b_lit%0d", j), qget(litb_q, j), B_BASE << j);
        check($sformatf("b_gap%0d", j), qget(latchb_t, j + 1) - qget(latchb_t, j), B_SHIFT + 3);
      end
      en_b = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
